// File: rtl/l2_arb_pkg.sv
// Shared types and default widths for the L2 front-end arbiter.
// l2_req_t is the request record at the default widths.
package l2_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                  read;
        logic                  write;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_LINE_W-1:0] wdata;
    } l2_req_t;

endpackage

// File: rtl/l2_arbiter_rr_pick2.sv
// Pure two-way round-robin picker: a lone requester always wins.
// On a tie, prio_d chooses the D side.
module l2_arbiter_rr_pick2 (
    input  logic req_i,
    input  logic req_d,
    input  logic prio_d,
    output logic gnt_i,
    output logic gnt_d
);

    assign gnt_i = req_i & (~req_d | ~prio_d);
    assign gnt_d = req_d & (~req_i |  prio_d);

endmodule

// File: rtl/l2_arbiter.sv
// Arbitrates L1 I-cache reads and D-cache reads/writebacks onto the single L2 port.
// One transaction is outstanding at a time; every response is followed by one IDLE cycle.
module l2_arbiter
    import l2_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic              l2_resp,
    input  logic [LINE_W-1:0] l2_rdata
);

    typedef struct packed {
        logic              read;
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } req_t;

    arb_state_t state_q, state_d;
    logic       prio_d_q, prio_d_d;
    req_t       l2_req_q, l2_req_d;

    logic cand_i, cand_d;
    logic gnt_i, gnt_d;

    assign cand_i = i_read;
    assign cand_d = d_read | d_write;

    l2_arbiter_rr_pick2 u_rr_pick2 (
        .req_i  (cand_i),
        .req_d  (cand_d),
        .prio_d (prio_d_q),
        .gnt_i  (gnt_i),
        .gnt_d  (gnt_d)
    );

    always_comb begin
        // NOTE: every next-state signal starts from its current value so no branch can infer a latch.
        state_d  = state_q;
        prio_d_d = prio_d_q;
        l2_req_d = l2_req_q;
        case (state_q)
            IDLE: begin
                if (gnt_i) begin
                    state_d        = SERVE_I;
                    prio_d_d       = 1'b1;
                    l2_req_d.read  = 1'b1;
                    l2_req_d.write = 1'b0;
                    l2_req_d.addr  = i_addr;
                end else if (gnt_d) begin
                    // A writeback wins over a read when both strobes are up.
                    state_d        = SERVE_D;
                    prio_d_d       = 1'b0;
                    l2_req_d.read  = ~d_write;
                    l2_req_d.write = d_write;
                    l2_req_d.addr  = d_addr;
                    l2_req_d.wdata = d_wdata;
                end
            end
            SERVE_I, SERVE_D: begin
                if (l2_resp) begin
                    state_d        = IDLE;
                    l2_req_d.read  = 1'b0;
                    l2_req_d.write = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: flops use non-blocking assignments so every register samples the pre-edge values together.
        if (!rst) begin
            state_q  <= IDLE;
            prio_d_q <= 1'b0;
            l2_req_q <= '0;
        end else begin
            state_q  <= state_d;
            prio_d_q <= prio_d_d;
            l2_req_q <= l2_req_d;
        end
    end

    assign l2_read  = l2_req_q.read;
    assign l2_write = l2_req_q.write;
    assign l2_addr  = l2_req_q.addr;
    assign l2_wdata = l2_req_q.wdata;

    // Response steering decodes only registered state, so l2_resp never reaches l2_read/l2_write.
    assign i_resp  = l2_resp & (state_q == SERVE_I);
    assign d_resp  = l2_resp & (state_q == SERVE_D);
    assign i_rdata = l2_rdata;
    assign d_rdata = l2_rdata;

endmodule

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
- Two-port arbiter in front of the shared L2 cache. It multiplexes L1 I-cache line reads and L1 D-cache line reads/writebacks onto the single L2 request port.
- Registers the winning request and routes the L2 response back to the granted requester.
- Round-robin priority on simultaneous requests. One transaction is outstanding at a time.

Parameters:
- ADDR_W, 32, byte address width of every port
- LINE_W, 256, cache line width (bits) of every data port

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset; rst=0 resets on the rising edge of clk
- i_read  in  1  I-cache line read request; held until i_resp
- i_addr  in  ADDR_W  I-cache line address
- i_resp  out  1  I-cache response strobe, one cycle
- i_rdata  out  LINE_W  line returned to I-cache, valid when i_resp=1
- d_read  in  1  D-cache line read request; held until d_resp
- d_write  in  1  D-cache line write request; held until d_resp
- d_addr  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  D-cache write line
- d_resp  out  1  D-cache response strobe, one cycle
- d_rdata  out  LINE_W  line returned to D-cache, valid when d_resp=1
- l2_read  out  1  read request to L2, registered
- l2_write  out  1  write request to L2, registered
- l2_addr  out  ADDR_W  registered request address
- l2_wdata  out  LINE_W  registered write data
- l2_resp  in  1  L2 completion strobe
- l2_rdata  in  LINE_W  L2 read line, valid with l2_resp

Behaviour:
- States: IDLE, SERVE_I, SERVE_D, plus a priority register prio_d. prio_d=0 means the I-cache wins ties.
- Reset (rst=0 at posedge):
  - state=IDLE, prio_d=0.
  - l2_read=l2_write=0, l2_addr=0, l2_wdata=0.
  - Any in-flight transaction is abandoned; no resp is generated for it.
  - Requests present during reset are ignored until the first non-reset edge.
- i_resp, d_resp, i_rdata, d_rdata are combinational:
  - i_resp = l2_resp & (state==SERVE_I); d_resp = l2_resp & (state==SERVE_D).
  - i_rdata = d_rdata = l2_rdata, passthrough.
  - All are 0 / don't-care during reset and in IDLE. An l2_resp seen in IDLE is ignored.
- IDLE arbitration, at edge t:
  - Candidates: req_i = i_read; req_d = d_read | d_write.
  - Only one candidate → grant it.
  - Both → grant D if prio_d=1, else I.
  - On grant: latch addr; for D also latch wdata and op. State moves to SERVE_x.
  - l2_read or l2_write asserts from cycle t+1; l2_addr/l2_wdata are stable for the whole transaction.
  - prio_d updates at grant: grant I → prio_d=1; grant D → prio_d=0.
- D op encoding: d_write=1 → l2_write=1, l2_read=0, with write taking precedence if both d_read and d_write are asserted. Otherwise l2_read=1, l2_write=0. l2_wdata is latched even for reads; it is don't-care at L2.
- SERVE_x:
  - Hold all L2 outputs until l2_resp=1.
  - In the l2_resp cycle: pulse x_resp, then return to IDLE. l2_read/l2_write drop at the next edge.
- Mandatory IDLE turnaround cycle after every response. It guarantees the just-served requester has dropped its request before re-arbitration.
- Minimum request-to-resp latency: 1 cycle plus L2 latency.
- Requester inputs are not re-sampled after grant. Changes to addr/data mid-transaction have no effect.
- A request from the losing port stays pending; it is granted in the turnaround IDLE cycle if still asserted.
- Starvation bound: each requester waits at most one other transaction.
- No combinational path from l2_resp to l2_read/l2_write.

Decomposition:
- Shared package (l2_arb_pkg) holds:
  - enum arb_state_t {IDLE, SERVE_I, SERVE_D}
  - typedef l2_req_t struct: read, write, addr, wdata
  - ADDR_W/LINE_W default constants
- Optional sub-module rr_pick2: pure 2-way round-robin picker (req_i, req_d, prio_d → gnt_i, gnt_d). Everything else stays flat in l2_arbiter.

Test Plan:
- I only:
  - Stimulus: i_read=1, i_addr=0x0000_1000; L2 responds 3 cycles after l2_read rises with l2_rdata=0xA5..A5.
  - Required: l2_read=1, l2_addr=0x1000 from the cycle after the request; i_resp=1 for one cycle with i_rdata=0xA5..A5; d_resp stays 0; l2_read=0 the next cycle.
- D writeback:
  - Stimulus: d_write=1, d_addr=0x0000_2040, d_wdata=0x1234..; L2 resp after 2 cycles.
  - Required: l2_write=1, l2_read=0, l2_wdata=0x1234..; d_resp pulses once.
- Simultaneous after reset:
  - Stimulus: i_read and d_read both asserted.
  - Required: I granted first (prio_d=0); D granted in the IDLE cycle after i_resp. A second simultaneous pair then grants I again, because serving D reset prio_d=0.
- Back-to-back D:
  - Stimulus: d_read held and re-asserted immediately after d_resp; i_read held throughout.
  - Required: I served between the two D transactions; no two consecutive D grants while I is pending.
- Reset mid-transaction:
  - Stimulus: rst=0 for one edge while in SERVE_D with l2_write=1.
  - Required: next cycle state=IDLE, l2_write=0, no d_resp; a late l2_resp is ignored.
- Mid-transaction address change:
  - Stimulus: change i_addr from 0x100 to 0x200 during SERVE_I.
  - Required: l2_addr stays 0x100 until i_resp.
